// File: rtl/prco_lsu_pkg.sv
// -----------------------------------------------------------------------------
// prco_lsu_pkg
// Shared constants for the PRCO load/store/writeback stage:
//   - PRCO_OP_* opcode encodings (5-bit ISA opcode field)
//   - LSU FSM state encodings
//   - q_fault bit indices
//   - helper deciding whether a register-path opcode writes the register file
// -----------------------------------------------------------------------------
package prco_lsu_pkg;

  localparam int PRCO_OP_W = 5;

  localparam logic [PRCO_OP_W-1:0] PRCO_OP_NOP   = 5'd0;
  localparam logic [PRCO_OP_W-1:0] PRCO_OP_MOV   = 5'd1;
  localparam logic [PRCO_OP_W-1:0] PRCO_OP_MOVI  = 5'd2;
  localparam logic [PRCO_OP_W-1:0] PRCO_OP_ADD   = 5'd3;
  localparam logic [PRCO_OP_W-1:0] PRCO_OP_ADDI  = 5'd4;
  localparam logic [PRCO_OP_W-1:0] PRCO_OP_SUBI  = 5'd5;
  localparam logic [PRCO_OP_W-1:0] PRCO_OP_CMP   = 5'd6;
  localparam logic [PRCO_OP_W-1:0] PRCO_OP_JMP   = 5'd7;
  localparam logic [PRCO_OP_W-1:0] PRCO_OP_LW    = 5'd8;
  localparam logic [PRCO_OP_W-1:0] PRCO_OP_SW    = 5'd9;
  localparam logic [PRCO_OP_W-1:0] PRCO_OP_READ  = 5'd10;
  localparam logic [PRCO_OP_W-1:0] PRCO_OP_WRITE = 5'd11;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_STORE = 2'd1,
    LSU_LOAD  = 2'd2
  } lsu_state_t;

  localparam int LSU_F_TIMEOUT = 0;
  localparam int LSU_F_PROTO   = 1;

  // Wait counter width; covers the full 1..255 timeout range.
  localparam int LSU_CNT_W = 8;

  // Register-path opcodes that produce a register-file write.
  function automatic logic lsu_writes_reg(input logic [PRCO_OP_W-1:0] op);
    logic wr;
    case (op)
      PRCO_OP_MOV, PRCO_OP_MOVI, PRCO_OP_ADD,
      PRCO_OP_ADDI, PRCO_OP_SUBI, PRCO_OP_READ: wr = 1'b1;
      default:                                  wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/prco_lsu_wait_timer.sv
// -----------------------------------------------------------------------------
// prco_lsu_wait_timer
// Counts memory wait cycles for an in-flight RAM access.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : reset the count to zero (new access / access finished)
//   i_inc          : one more cycle spent waiting for i_mem_ready
//   q_expired      : the current wait cycle is the P_TIMEOUT-th one, so an
//                    increment now would make the count reach P_TIMEOUT
// -----------------------------------------------------------------------------
module prco_lsu_wait_timer
  import prco_lsu_pkg::*;
#(
  parameter int P_TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic q_expired
);

  localparam logic [LSU_CNT_W-1:0] L_LAST = LSU_CNT_W'(P_TIMEOUT - 1);

  logic [LSU_CNT_W-1:0] r_count;

  // Clear has priority so a finishing access and a new acceptance never
  // leave a stale count behind.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Flag one cycle early so the abort happens on the edge where the count
  // would reach P_TIMEOUT, i.e. after exactly P_TIMEOUT wait cycles.
  assign q_expired = (r_count == L_LAST);

endmodule

// File: rtl/prco_lsu.sv
// -----------------------------------------------------------------------------
// prco_lsu
// Load/store and writeback stage following the PRCO ALU.
// Ports:
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_ce_ram / i_ce_reg     : one-cycle valid pulses for memory / register ops
//   i_op, i_result          : opcode and ALU result (address or write value)
//   i_store_data, i_rd      : SW store value, destination register index
//   q_mem_addr/wdata/we/re  : data-RAM request, held until i_mem_ready
//   i_mem_rdata/i_mem_ready : data-RAM response
//   q_reg_we/sel/data       : one-cycle register-file write
//   q_done                  : one-cycle retire pulse
//   q_busy                  : memory access in flight, upstream stalls
//   q_fault                 : sticky [0] timeout, [1] protocol violation
// -----------------------------------------------------------------------------
module prco_lsu
  import prco_lsu_pkg::*;
#(
  parameter int P_ADDR_W  = 16,
  parameter int P_TIMEOUT = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_ce_ram,
  input  logic                 i_ce_reg,
  input  logic [PRCO_OP_W-1:0] i_op,
  input  logic [15:0]          i_result,
  input  logic [15:0]          i_store_data,
  input  logic [2:0]           i_rd,
  output logic [P_ADDR_W-1:0]  q_mem_addr,
  output logic [15:0]          q_mem_wdata,
  output logic                 q_mem_we,
  output logic                 q_mem_re,
  input  logic [15:0]          i_mem_rdata,
  input  logic                 i_mem_ready,
  output logic                 q_reg_we,
  output logic [2:0]           q_reg_sel,
  output logic [15:0]          q_reg_data,
  output logic                 q_done,
  output logic                 q_busy,
  output logic [1:0]           q_fault
);

  lsu_state_t          r_state;
  logic [P_ADDR_W-1:0] r_mem_addr;
  logic [15:0]         r_mem_wdata;
  logic                r_mem_we;
  logic                r_mem_re;
  logic [2:0]          r_rd;
  logic                r_reg_we;
  logic [2:0]          r_reg_sel;
  logic [15:0]         r_reg_data;
  logic                r_done;
  logic [1:0]          r_fault;

  lsu_state_t          w_state_nxt;
  logic [P_ADDR_W-1:0] w_mem_addr_nxt;
  logic [15:0]         w_mem_wdata_nxt;
  logic                w_mem_we_nxt;
  logic                w_mem_re_nxt;
  logic [2:0]          w_rd_nxt;
  logic                w_reg_we_nxt;
  logic [2:0]          w_reg_sel_nxt;
  logic [15:0]         w_reg_data_nxt;
  logic                w_done_nxt;
  logic [1:0]          w_fault_nxt;
  logic                w_tmr_clr;
  logic                w_tmr_inc;
  logic                w_tmr_expired;

  prco_lsu_wait_timer #(
    .P_TIMEOUT (P_TIMEOUT)
  ) u_wait_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_tmr_clr),
    .i_inc     (w_tmr_inc),
    .q_expired (w_tmr_expired)
  );

  // Next-state and next-output logic. Strobes (reg_we, done) default low so
  // they can only ever be high for a single cycle; request, address and
  // data default to holding so an in-flight access stays stable.
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_we_nxt    = r_mem_we;
    w_mem_re_nxt    = r_mem_re;
    w_rd_nxt        = r_rd;
    w_reg_we_nxt    = 1'b0;
    w_reg_sel_nxt   = r_reg_sel;
    w_reg_data_nxt  = r_reg_data;
    w_done_nxt      = 1'b0;
    w_fault_nxt     = r_fault;
    w_tmr_clr       = 1'b0;
    w_tmr_inc       = 1'b0;

    case (r_state)
      LSU_IDLE: begin
        if (i_ce_ram) begin
          // RAM path wins a collision; the register request is lost.
          if (i_ce_reg) begin
            w_fault_nxt[LSU_F_PROTO] = 1'b1;
          end
          w_mem_addr_nxt  = i_result[P_ADDR_W-1:0];
          w_mem_wdata_nxt = i_store_data;
          w_rd_nxt        = i_rd;
          w_tmr_clr       = 1'b1;
          if (i_op == PRCO_OP_SW) begin
            w_mem_we_nxt = 1'b1;
            w_state_nxt  = LSU_STORE;
          end else begin
            w_mem_re_nxt = 1'b1;
            w_state_nxt  = LSU_LOAD;
          end
        end else if (i_ce_reg) begin
          w_done_nxt = 1'b1;
          if (lsu_writes_reg(i_op)) begin
            w_reg_we_nxt   = 1'b1;
            w_reg_sel_nxt  = i_rd;
            w_reg_data_nxt = i_result;
          end
        end
      end

      LSU_STORE, LSU_LOAD: begin
        // New work while occupied is a protocol error and is not accepted.
        if (i_ce_ram || i_ce_reg) begin
          w_fault_nxt[LSU_F_PROTO] = 1'b1;
        end
        if (i_mem_ready) begin
          w_mem_we_nxt = 1'b0;
          w_mem_re_nxt = 1'b0;
          w_done_nxt   = 1'b1;
          w_tmr_clr    = 1'b1;
          w_state_nxt  = LSU_IDLE;
          if (r_state == LSU_LOAD) begin
            w_reg_we_nxt   = 1'b1;
            w_reg_sel_nxt  = r_rd;
            w_reg_data_nxt = i_mem_rdata;
          end
        end else if (w_tmr_expired) begin
          w_mem_we_nxt               = 1'b0;
          w_mem_re_nxt               = 1'b0;
          w_done_nxt                 = 1'b1;
          w_fault_nxt[LSU_F_TIMEOUT] = 1'b1;
          w_tmr_clr                  = 1'b1;
          w_state_nxt                = LSU_IDLE;
        end else begin
          w_tmr_inc = 1'b1;
        end
      end

      default: begin
        w_state_nxt  = LSU_IDLE;
        w_mem_we_nxt = 1'b0;
        w_mem_re_nxt = 1'b0;
        w_tmr_clr    = 1'b1;
      end
    endcase
  end

  // State and registered outputs. Async reset drops any in-flight access
  // immediately, without a register write or retire pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= LSU_IDLE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_rd        <= '0;
      r_reg_we    <= 1'b0;
      r_reg_sel   <= '0;
      r_reg_data  <= '0;
      r_done      <= 1'b0;
      r_fault     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_re    <= w_mem_re_nxt;
      r_rd        <= w_rd_nxt;
      r_reg_we    <= w_reg_we_nxt;
      r_reg_sel   <= w_reg_sel_nxt;
      r_reg_data  <= w_reg_data_nxt;
      r_done      <= w_done_nxt;
      r_fault     <= w_fault_nxt;
    end
  end

  assign q_mem_addr  = r_mem_addr;
  assign q_mem_wdata = r_mem_wdata;
  assign q_mem_we    = r_mem_we;
  assign q_mem_re    = r_mem_re;
  assign q_reg_we    = r_reg_we;
  assign q_reg_sel   = r_reg_sel;
  assign q_reg_data  = r_reg_data;
  assign q_done      = r_done;
  assign q_busy      = (r_state != LSU_IDLE);
  assign q_fault     = r_fault;

endmodule

// File: tb/tb_prco_lsu.sv
// -----------------------------------------------------------------------------
// tb_prco_lsu
// Self-checking bench for prco_lsu (P_TIMEOUT=4). Every retire is predicted
// by pushing an entry to a scoreboard when the instruction is driven; a
// monitor pops and compares on each q_done pulse.
// -----------------------------------------------------------------------------
module tb_prco_lsu;
  import prco_lsu_pkg::*;

  logic                 i_clk;
  logic                 i_rst_n;
  logic                 i_ce_ram;
  logic                 i_ce_reg;
  logic [PRCO_OP_W-1:0] i_op;
  logic [15:0]          i_result;
  logic [15:0]          i_store_data;
  logic [2:0]           i_rd;
  logic [15:0]          q_mem_addr;
  logic [15:0]          q_mem_wdata;
  logic                 q_mem_we;
  logic                 q_mem_re;
  logic [15:0]          i_mem_rdata;
  logic                 i_mem_ready;
  logic                 q_reg_we;
  logic [2:0]           q_reg_sel;
  logic [15:0]          q_reg_data;
  logic                 q_done;
  logic                 q_busy;
  logic [1:0]           q_fault;

  typedef struct {
    logic        we;
    logic [2:0]  sel;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   compareCount = 0;
  int   failCount    = 0;

  prco_lsu #(
    .P_ADDR_W  (16),
    .P_TIMEOUT (4)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_ce_ram     (i_ce_ram),
    .i_ce_reg     (i_ce_reg),
    .i_op         (i_op),
    .i_result     (i_result),
    .i_store_data (i_store_data),
    .i_rd         (i_rd),
    .q_mem_addr   (q_mem_addr),
    .q_mem_wdata  (q_mem_wdata),
    .q_mem_we     (q_mem_we),
    .q_mem_re     (q_mem_re),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_ready  (i_mem_ready),
    .q_reg_we     (q_reg_we),
    .q_reg_sel    (q_reg_sel),
    .q_reg_data   (q_reg_data),
    .q_done       (q_done),
    .q_busy       (q_busy),
    .q_fault      (q_fault)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compareCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic void pushExp(input logic we, input logic [2:0] sel, input logic [15:0] data);
    exp_t e;
    e.we   = we;
    e.sel  = sel;
    e.data = data;
    sb.push_back(e);
  endfunction

  // Called at a falling edge; drives one pulse that the next rising edge
  // samples, then returns at the following falling edge with the pulse gone.
  task automatic applyStimulus(input logic ceRam, input logic ceReg,
                               input logic [PRCO_OP_W-1:0] op, input logic [15:0] result,
                               input logic [15:0] storeData, input logic [2:0] rd);
    i_ce_ram     = ceRam;
    i_ce_reg     = ceReg;
    i_op         = op;
    i_result     = result;
    i_store_data = storeData;
    i_rd         = rd;
    @(negedge i_clk);
    i_ce_ram = 1'b0;
    i_ce_reg = 1'b0;
  endtask

  // Scoreboard monitor: each retire pops one prediction; a register write
  // without a retire is always wrong.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (q_done) begin
        if (sb.size() == 0) begin
          checkOutput("sb_unexpected_done", 32'(q_done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("sb_reg_we", 32'(q_reg_we), 32'(e.we));
          if (e.we) begin
            checkOutput("sb_reg_sel", 32'(q_reg_sel), 32'(e.sel));
            checkOutput("sb_reg_data", 32'(q_reg_data), 32'(e.data));
          end
        end
      end else if (q_reg_we) begin
        checkOutput("stray_reg_we", 32'(q_reg_we), 32'd0);
      end
    end
  end

  initial begin
    i_rst_n      = 1'b0;
    i_ce_ram     = 1'b0;
    i_ce_reg     = 1'b0;
    i_op         = PRCO_OP_NOP;
    i_result     = '0;
    i_store_data = '0;
    i_rd         = '0;
    i_mem_rdata  = '0;
    i_mem_ready  = 1'b0;

    // Reset state.
    repeat (2) @(negedge i_clk);
    checkOutput("rst_mem_we",  32'(q_mem_we),  32'd0);
    checkOutput("rst_mem_re",  32'(q_mem_re),  32'd0);
    checkOutput("rst_reg_we",  32'(q_reg_we),  32'd0);
    checkOutput("rst_done",    32'(q_done),    32'd0);
    checkOutput("rst_busy",    32'(q_busy),    32'd0);
    checkOutput("rst_fault",   32'(q_fault),   32'd0);
    checkOutput("rst_addr",    32'(q_mem_addr), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Register writeback, one cycle only.
    pushExp(1'b1, 3'd3, 16'h1234);
    applyStimulus(1'b0, 1'b1, PRCO_OP_ADD, 16'h1234, 16'h0, 3'd3);
    checkOutput("add_reg_we", 32'(q_reg_we), 32'd1);
    checkOutput("add_busy",   32'(q_busy),   32'd0);
    @(negedge i_clk);
    checkOutput("add_we_once",   32'(q_reg_we), 32'd0);
    checkOutput("add_done_once", 32'(q_done),   32'd0);

    // Retire-only opcodes.
    pushExp(1'b0, 3'd0, 16'h0);
    applyStimulus(1'b0, 1'b1, PRCO_OP_CMP, 16'hAAAA, 16'h0, 3'd1);
    pushExp(1'b1, 3'd6, 16'hC0DE);
    applyStimulus(1'b0, 1'b1, PRCO_OP_MOVI, 16'hC0DE, 16'h0, 3'd6);
    pushExp(1'b0, 3'd0, 16'h0);
    applyStimulus(1'b0, 1'b1, PRCO_OP_WRITE, 16'h5A5A, 16'h0, 3'd2);
    @(negedge i_clk);

    // Zero-wait store.
    i_mem_ready = 1'b1;
    pushExp(1'b0, 3'd0, 16'h0);
    applyStimulus(1'b1, 1'b0, PRCO_OP_SW, 16'h0040, 16'hBEEF, 3'd0);
    checkOutput("sw_we",    32'(q_mem_we),    32'd1);
    checkOutput("sw_re",    32'(q_mem_re),    32'd0);
    checkOutput("sw_addr",  32'(q_mem_addr),  32'h0040);
    checkOutput("sw_wdata", 32'(q_mem_wdata), 32'hBEEF);
    checkOutput("sw_busy",  32'(q_busy),      32'd1);
    @(negedge i_clk);
    checkOutput("sw_we_drop", 32'(q_mem_we), 32'd0);
    checkOutput("sw_busy_0",  32'(q_busy),   32'd0);
    checkOutput("sw_done",    32'(q_done),   32'd1);
    i_mem_ready = 1'b0;
    @(negedge i_clk);

    // Load with three request cycles; inputs change after acceptance.
    pushExp(1'b1, 3'd5, 16'h00A5);
    applyStimulus(1'b1, 1'b0, PRCO_OP_LW, 16'h0010, 16'h0, 3'd5);
    i_result = 16'hFFFF;
    i_rd     = 3'd7;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("lw_re_%0d", i), 32'(q_mem_re), 32'd1);
      checkOutput($sformatf("lw_addr_%0d", i), 32'(q_mem_addr), 32'h0010);
      if (i == 2) begin
        i_mem_ready = 1'b1;
        i_mem_rdata = 16'h00A5;
      end
      @(negedge i_clk);
    end
    checkOutput("lw_re_drop", 32'(q_mem_re), 32'd0);
    checkOutput("lw_done",    32'(q_done),   32'd1);
    i_mem_ready = 1'b0;
    i_mem_rdata = 16'h0;
    @(negedge i_clk);

    // Timeout after four wait cycles, then normal writeback.
    pushExp(1'b0, 3'd0, 16'h0);
    applyStimulus(1'b1, 1'b0, PRCO_OP_LW, 16'h0020, 16'h0, 3'd2);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("to_re_%0d", i), 32'(q_mem_re), 32'd1);
      @(negedge i_clk);
    end
    checkOutput("to_re_drop", 32'(q_mem_re), 32'd0);
    checkOutput("to_done",    32'(q_done),   32'd1);
    checkOutput("to_fault",   32'(q_fault),  32'b01);
    pushExp(1'b1, 3'd1, 16'h5555);
    applyStimulus(1'b0, 1'b1, PRCO_OP_ADD, 16'h5555, 16'h0, 3'd1);
    @(negedge i_clk);

    // Both enables together: load wins, protocol fault raised.
    i_mem_ready = 1'b1;
    i_mem_rdata = 16'h0BAD;
    pushExp(1'b1, 3'd4, 16'h0BAD);
    applyStimulus(1'b1, 1'b1, PRCO_OP_LW, 16'h0030, 16'h0, 3'd4);
    checkOutput("both_re", 32'(q_mem_re), 32'd1);
    @(negedge i_clk);
    checkOutput("both_fault", 32'(q_fault), 32'b11);
    i_mem_ready = 1'b0;
    i_mem_rdata = 16'h0;
    @(negedge i_clk);

    // Async reset in the middle of a load.
    applyStimulus(1'b1, 1'b0, PRCO_OP_LW, 16'h0060, 16'h0, 3'd3);
    checkOutput("rl_re_before", 32'(q_mem_re), 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("rl_re",    32'(q_mem_re), 32'd0);
    checkOutput("rl_busy",  32'(q_busy),   32'd0);
    checkOutput("rl_fault", 32'(q_fault),  32'd0);
    checkOutput("rl_addr",  32'(q_mem_addr), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_mem_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    checkOutput("rl_busy_after", 32'(q_busy),  32'd0);
    checkOutput("rl_re_after",   32'(q_mem_re), 32'd0);
    i_mem_ready = 1'b0;

    // Register enable during a load is ignored; load still completes.
    pushExp(1'b1, 3'd6, 16'h7777);
    applyStimulus(1'b1, 1'b0, PRCO_OP_LW, 16'h0050, 16'h0, 3'd6);
    applyStimulus(1'b0, 1'b1, PRCO_OP_ADD, 16'h9999, 16'h0, 3'd2);
    checkOutput("proto_re_held", 32'(q_mem_re),   32'd1);
    checkOutput("proto_addr",    32'(q_mem_addr), 32'h0050);
    i_mem_ready = 1'b1;
    i_mem_rdata = 16'h7777;
    @(negedge i_clk);
    checkOutput("proto_done",  32'(q_done),  32'd1);
    checkOutput("proto_fault", 32'(q_fault), 32'b10);
    i_mem_ready = 1'b0;
    i_mem_rdata = 16'h0;

    repeat (4) @(negedge i_clk);
    checkOutput("sb_left", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/prco_lsu.md
Name: prco_lsu

Overview:
- Load/store and writeback stage directly downstream of the PRCO ALU.
- Consumes the ALU result together with its RAM/register enable pulses.
- RAM path: performs data-RAM reads/writes with a ready handshake and bounded wait.
- Register path: issues one registered register-file write per completed instruction, and raises busy so fetch/decode stall during memory access.

Parameters:
- P_ADDR_W, 16, data-RAM address width; low P_ADDR_W bits of i_result drive q_mem_addr.
- P_TIMEOUT, 15, max wait cycles for i_mem_ready before abort (range 1..255).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_ce_ram  in  1  one-cycle pulse from ALU: memory instruction valid.
- i_ce_reg  in  1  one-cycle pulse from ALU: register instruction valid.
- i_op  in  5  opcode (PRCO_OP_* encoding).
- i_result  in  16  ALU result: address for LW/SW, write value otherwise.
- i_store_data  in  16  register value to store for SW.
- i_rd  in  3  destination register index.
- q_mem_addr  out  P_ADDR_W  RAM address.
- q_mem_wdata  out  16  RAM write data.
- q_mem_we  out  1  RAM write request, held until ready.
- q_mem_re  out  1  RAM read request, held until ready.
- i_mem_rdata  in  16  RAM read data, valid when i_mem_ready is high during a read.
- i_mem_ready  in  1  RAM completion strobe.
- q_reg_we  out  1  register-file write strobe, one cycle.
- q_reg_sel  out  3  register-file write index.
- q_reg_data  out  16  register-file write data.
- q_done  out  1  one-cycle retire pulse.
- q_busy  out  1  stage occupied; upstream must stall.
- q_fault  out  2  sticky: [0] memory timeout, [1] protocol violation.

Behaviour:
- Reset (async on i_rst_n low): state IDLE; all outputs 0; wait counter 0; q_fault cleared.
- Reset asserted mid-access drops the request with no register write and no q_done.
- States are IDLE, STORE and LOAD.
- IDLE, i_ce_reg high at edge N:
  - Opcodes MOV, MOVI, ADD, ADDI, SUBI and READ: q_reg_we=1, q_reg_sel=i_rd, q_reg_data=i_result, q_done=1, all for the cycle after N.
  - CMP, JMP, NOP, WRITE and any other opcode: q_done=1 only, no register write.
  - Latency 1; stays in IDLE.
- IDLE, i_ce_ram high, i_op=SW at edge N:
  - q_mem_we=1, q_mem_addr=i_result[P_ADDR_W-1:0], q_mem_wdata=i_store_data; go to STORE; q_busy=1.
- IDLE, i_ce_ram high, any other op (LW) at edge N:
  - q_mem_re=1 with the address as above; go to LOAD; q_busy=1.
- STORE or LOAD, request held stable each cycle. At each edge, i_mem_ready is sampled:
  - Ready high: drop we/re, q_busy=0, q_done=1 next cycle, return to IDLE. LOAD also drives q_reg_we=1, q_reg_sel=latched rd and q_reg_data=i_mem_rdata in that same cycle.
  - Ready already high on the first request cycle completes in one wait cycle (minimum 2-cycle memory latency, accept to done).
  - Ready low: increment the wait counter. When the counter reaches P_TIMEOUT, abort: drop request, set q_fault[0], pulse q_done with no register write, return to IDLE, counter 0.
- i_mem_ready in IDLE is ignored.
- i_ce_ram and i_ce_reg both high: RAM path wins, register request is dropped, q_fault[1] is set.
- i_ce_ram or i_ce_reg high while in STORE or LOAD: ignored, q_fault[1] is set, the in-flight access is unaffected.
- Address and data are latched at acceptance; later changes on i_result, i_store_data and i_rd have no effect.
- q_fault bits stay set until reset.
- q_reg_we and q_done are never high for more than one consecutive cycle per instruction.

Decomposition:
- Shared package/include: reuse the existing PRCO_OP_* opcodes from the ISA include. Add LSU state encodings (LSU_IDLE=2'd0, LSU_STORE=2'd1, LSU_LOAD=2'd2) and fault bit indices (LSU_F_TIMEOUT=0, LSU_F_PROTO=1) to the constants include.
- Sub-module: prco_lsu_wait_timer holds the wait counter (load/clear/increment, expired flag at P_TIMEOUT). Everything else stays flat.

Test Plan:
- Register writeback: i_ce_reg pulse, op=ADD, i_result=16'h1234, i_rd=3 -> next cycle q_reg_we=1, q_reg_sel=3, q_reg_data=16'h1234, q_done=1; one cycle only.
- Zero-wait store: SW, i_result=16'h0040, i_store_data=16'hBEEF, i_mem_ready tied high -> q_mem_we=1 with addr 0x0040, data 0xBEEF for 1 cycle. Next cycle q_done=1, q_busy=0, no q_reg_we.
- Load with wait states: LW, i_result=16'h0010, i_rd=5, ready asserted 3 cycles after request with i_mem_rdata=16'h00A5 -> q_mem_re held 3 cycles, then q_reg_we=1, q_reg_sel=5, q_reg_data=16'h00A5, q_done=1.
- Timeout: LW, ready never asserted, P_TIMEOUT=4 -> request dropped after 4 wait cycles; q_fault=2'b01; q_done pulses with q_reg_we=0; a following ADD still writes back normally.
- Protocol errors:
  - i_ce_ram and i_ce_reg pulsed together with op=LW -> load performed, no register-path write, q_fault[1]=1.
  - i_ce_reg pulsed during LOAD -> ignored, load completes correctly.
- Async reset mid-load: deassert i_rst_n between clock edges during LOAD -> outputs 0 immediately. After release: no q_reg_we, no q_done, state IDLE, q_fault=0.
